// File: rtl/ahb_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_cmd_arbiter
//   Shares the single command/response port of an AHB master between
//   NUM_REQ requesters. Arbitration is round-robin. A grant is held for the
//   whole transaction: for writes until the master accepts the command, for
//   reads until the read data has been handed back to the issuing requester.
//
// Optional feature (compile-time macro AHB_ARB_RSP_TIMEOUT_EN):
//   Read-response watchdog. If the master does not return read data within
//   TIMEOUT_CYCLES cycles, the requester gets a one-cycle 32'hDEAD_BEEF
//   response, timeout_o pulses, and the arbiter returns to IDLE. Without the
//   macro there is no timer, timeout_o is tied low, and RSP waits forever.
//
// Ports:
//   hclk, hreset   clock, asynchronous active-high reset
//   req_*_i/o      per-requester command side (packed by requester index)
//   rsp_*          per-requester read-data side (rdata shared by all)
//   m_din_*, m_wr_en_o, m_rd_en_o, m_data_size_o, m_addr_o, m_wdata_o
//                  command port to the AHB master
//   m_dout_*, m_rdata_i
//                  read-data port from the AHB master
//   timeout_o      one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module ahb_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GNT_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_REQ-1:0]    req_vld_i,
  output logic [NUM_REQ-1:0]    req_rdy_o,
  input  logic [NUM_REQ-1:0]    req_wr_en_i,
  input  logic [NUM_REQ-1:0]    req_rd_en_i,
  input  logic [3*NUM_REQ-1:0]  req_size_i,
  input  logic [32*NUM_REQ-1:0] req_addr_i,
  input  logic [32*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]    rsp_vld_o,
  output logic [31:0]           rsp_rdata_o,
  input  logic [NUM_REQ-1:0]    rsp_rdy_i,
  output logic                  m_din_vld_o,
  input  logic                  m_din_rdy_i,
  output logic                  m_wr_en_o,
  output logic                  m_rd_en_o,
  output logic [2:0]            m_data_size_o,
  output logic [31:0]           m_addr_o,
  output logic [31:0]           m_wdata_o,
  input  logic                  m_dout_vld_i,
  input  logic [31:0]           m_rdata_i,
  output logic                  m_dout_rdy_o,
  output logic                  timeout_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  logic [1:0]       state;
  logic [GNT_W-1:0] gnt_idx;
  logic [GNT_W-1:0] last_gnt;
  logic [GNT_W-1:0] pick_idx;
  logic             pick_found;
  logic             g_wr;
  logic             g_rd;
  logic             cmd_is_read;
  logic             rsp_hs;
  logic             rsp_abort;

  // Round-robin pick: first requesting index above last_gnt, wrapping.
  // NOTE: every variable written in an always_comb gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && req_vld_i[(int'(last_gnt) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = GNT_W'((int'(last_gnt) + k) % NUM_REQ);
      end
    end
  end

  assign g_wr        = req_wr_en_i[gnt_idx];
  assign g_rd        = req_rd_en_i[gnt_idx];
  // Write wins when a requester sets both enables.
  assign cmd_is_read = g_rd & ~g_wr;
  assign rsp_hs      = (state == ST_RSP) & m_dout_vld_i & rsp_rdy_i[gnt_idx];

`ifdef AHB_ARB_RSP_TIMEOUT_EN
  logic [15:0] timer;
  logic        timeout_hit;

  assign timeout_hit = (state == ST_RSP) & ~rsp_hs &
                       (timer == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_abort   = timeout_hit;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      timer <= '0;
    end else if (state == ST_CMD && m_din_rdy_i && cmd_is_read) begin
      timer <= '0;
    end else if (state == ST_RSP && !rsp_hs) begin
      timer <= timer + 16'd1;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign rsp_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= ST_IDLE;
      gnt_idx  <= '0;
      last_gnt <= GNT_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt_idx  <= pick_idx;
            last_gnt <= pick_idx;
            state    <= ST_CMD;
          end
        end
        ST_CMD: begin
          // Accept cycle always returns through IDLE: one bubble per transfer.
          if (m_din_rdy_i) state <= cmd_is_read ? ST_RSP : ST_IDLE;
        end
        ST_RSP: begin
          if (rsp_hs || rsp_abort) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_rdy_o     = '0;
    rsp_vld_o     = '0;
    rsp_rdata_o   = '0;
    m_din_vld_o   = 1'b0;
    m_wr_en_o     = 1'b0;
    m_rd_en_o     = 1'b0;
    m_data_size_o = '0;
    m_addr_o      = '0;
    m_wdata_o     = '0;
    m_dout_rdy_o  = 1'b1;  // drain stray master data outside RSP
    timeout_o     = 1'b0;
    case (state)
      ST_CMD: begin
        m_din_vld_o        = 1'b1;
        m_wr_en_o          = g_wr;
        m_rd_en_o          = cmd_is_read;
        m_data_size_o      = req_size_i[int'(gnt_idx)*3 +: 3];
        m_addr_o           = req_addr_i[int'(gnt_idx)*32 +: 32];
        m_wdata_o          = req_wdata_i[int'(gnt_idx)*32 +: 32];
        req_rdy_o[gnt_idx] = m_din_rdy_i;
      end
      ST_RSP: begin
        rsp_vld_o[gnt_idx] = m_dout_vld_i;
        rsp_rdata_o        = m_rdata_i;
        m_dout_rdy_o       = rsp_rdy_i[gnt_idx];
`ifdef AHB_ARB_RSP_TIMEOUT_EN
        if (timeout_hit) begin
          rsp_vld_o[gnt_idx] = 1'b1;
          rsp_rdata_o        = 32'hDEAD_BEEF;
          timeout_o          = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule
